// File: rtl/overcooked_pkg.sv
// Shared object-grid types and cell codes for the grid controller and sprite renderer.
package overcooked_pkg;

  localparam int unsigned GRID_W = 13;
  localparam int unsigned GRID_H = 8;

  typedef logic [3:0] cell_t;
  typedef cell_t [GRID_H-1:0][GRID_W-1:0] grid_t;

  localparam cell_t G_EMPTY         = 4'd0;
  localparam cell_t G_ONION_WHOLE   = 4'd1;
  localparam cell_t G_ONION_CHOPPED = 4'd2;
  localparam cell_t G_POT_EMPTY     = 4'd3;
  localparam cell_t G_POT_RAW       = 4'd4;
  localparam cell_t G_POT_COOKED    = 4'd5;
  localparam cell_t G_POT_FIRE      = 4'd6;
  localparam cell_t G_PLATE         = 4'd7;
  localparam cell_t G_SOUP          = 4'd8;
  localparam cell_t G_EXTINGUISHER  = 4'd9;

  typedef enum logic {StIdle, StScan} ctrl_state_e;

endpackage

// File: rtl/cook_step.sv
// Combinational per-cell cooking step: advances a pot's code and age by one frame.
module cook_step
  import overcooked_pkg::*;
#(
  parameter int unsigned COOK_FRAMES = 180,
  parameter int unsigned BURN_FRAMES = 300,
  parameter int unsigned AGE_W       = 9
) (
  input  cell_t            code,
  input  logic [AGE_W-1:0] age,
  output cell_t            next_code,
  output logic [AGE_W-1:0] next_age
);

  logic [AGE_W-1:0] age_inc;
  assign age_inc = age + AGE_W'(1);

  // Transition fires on equality, so the age never passes its limit.
  always_comb begin
    next_code = code;
    next_age  = '0;
    case (code)
      G_POT_RAW: begin
        if (age_inc == AGE_W'(COOK_FRAMES)) next_code = G_POT_COOKED;
        else next_age = age_inc;
      end
      G_POT_COOKED: begin
        if (age_inc == AGE_W'(BURN_FRAMES)) next_code = G_POT_FIRE;
        else next_age = age_inc;
      end
      default: next_age = '0;
    endcase
  end

endmodule

// File: rtl/grid_state_controller.sv
// Object grid owner: arbitrates two-player compare-and-swap writes and runs the per-frame cook scan.
module grid_state_controller
  import overcooked_pkg::*;
#(
  parameter int unsigned COOK_FRAMES = 180,
  parameter int unsigned BURN_FRAMES = 300,
  parameter int unsigned AGE_W       = 9,
  parameter grid_t       INIT_GRID   = '0
) (
  input  logic            pixel_clk_in,
  input  logic            rst_in,
  input  logic            frame_tick_in,
  input  logic [1:0]      req_in,
  input  logic [1:0][3:0] req_x_in,
  input  logic [1:0][2:0] req_y_in,
  input  logic [1:0][3:0] req_expect_in,
  input  logic [1:0][3:0] req_value_in,
  output logic [1:0]      ack_out,
  output logic [1:0]      ok_out,
  output grid_t           object_grid_out,
  output logic            scan_busy_out
);

  typedef logic [GRID_H-1:0][GRID_W-1:0][AGE_W-1:0] age_grid_t;

  ctrl_state_e state_q, state_d;
  grid_t       grid_q, grid_d;
  age_grid_t   age_q, age_d;
  logic [3:0]  scan_x_q, scan_x_d;
  logic [2:0]  scan_y_q, scan_y_d;
  logic        tick_pending_q, tick_pending_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  ok_q, ok_d;

  logic [1:0]       elig;
  logic             gnt;
  logic [3:0]       gx, gx_safe;
  logic [2:0]       gy;
  logic             in_range, hit, scan_last;
  cell_t            step_code;
  logic [AGE_W-1:0] step_age;

  cook_step #(
    .COOK_FRAMES(COOK_FRAMES),
    .BURN_FRAMES(BURN_FRAMES),
    .AGE_W      (AGE_W)
  ) u_cook_step (
    .code     (grid_q[scan_y_q][scan_x_q]),
    .age      (age_q[scan_y_q][scan_x_q]),
    .next_code(step_code),
    .next_age (step_age)
  );

  // A port just acked is ineligible for one cycle so a held request is not regranted.
  assign elig      = req_in & ~ack_q;
  assign gnt       = (&elig) ? rr_ptr_q : elig[1];
  assign gx        = req_x_in[gnt];
  assign gy        = req_y_in[gnt];
  assign in_range  = gx < 4'(GRID_W);
  assign gx_safe   = in_range ? gx : 4'd0;
  assign hit       = in_range && (grid_q[gy][gx_safe] == req_expect_in[gnt]);
  assign scan_last = (scan_x_q == 4'(GRID_W - 1)) && (scan_y_q == 3'(GRID_H - 1));

  always_comb begin
    state_d        = state_q;
    grid_d         = grid_q;
    age_d          = age_q;
    scan_x_d       = scan_x_q;
    scan_y_d       = scan_y_q;
    tick_pending_d = tick_pending_q;
    rr_ptr_d       = rr_ptr_q;
    ack_d          = '0;
    ok_d           = '0;
    unique case (state_q)
      StIdle: begin
        if (frame_tick_in) begin
          state_d  = StScan;
          scan_x_d = '0;
          scan_y_d = '0;
        end else if (|elig) begin
          if (&elig) rr_ptr_d = ~rr_ptr_q;
          ack_d[gnt] = 1'b1;
          ok_d[gnt]  = hit;
          if (hit) begin
            grid_d[gy][gx_safe] = req_value_in[gnt];
            age_d[gy][gx_safe]  = '0;
          end
        end
      end
      StScan: begin
        grid_d[scan_y_q][scan_x_q] = step_code;
        age_d[scan_y_q][scan_x_q]  = step_age;
        if (frame_tick_in) tick_pending_d = 1'b1;
        if (scan_last) begin
          scan_x_d       = '0;
          scan_y_d       = '0;
          tick_pending_d = 1'b0;
          if (!(tick_pending_q || frame_tick_in)) state_d = StIdle;
        end else if (scan_x_q == 4'(GRID_W - 1)) begin
          scan_x_d = '0;
          scan_y_d = scan_y_q + 3'd1;
        end else begin
          scan_x_d = scan_x_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= StIdle;
      grid_q         <= INIT_GRID;
      age_q          <= '0;
      scan_x_q       <= '0;
      scan_y_q       <= '0;
      tick_pending_q <= 1'b0;
      rr_ptr_q       <= 1'b0;
      ack_q          <= '0;
      ok_q           <= '0;
    end else begin
      state_q        <= state_d;
      grid_q         <= grid_d;
      age_q          <= age_d;
      scan_x_q       <= scan_x_d;
      scan_y_q       <= scan_y_d;
      tick_pending_q <= tick_pending_d;
      rr_ptr_q       <= rr_ptr_d;
      ack_q          <= ack_d;
      ok_q           <= ok_d;
    end
  end

  assign ack_out         = ack_q;
  assign ok_out          = ok_q;
  assign object_grid_out = grid_q;
  assign scan_busy_out   = (state_q == StScan);

endmodule

// File: tb/tb_grid_state_controller.sv
// Directed self-checking bench for grid_state_controller with short cook/burn limits.
module tb_grid_state_controller;
  import overcooked_pkg::*;

  function automatic grid_t make_init();
    grid_t g;
    g = '0;
    g[2][3] = G_ONION_WHOLE;
    g[5][7] = G_POT_RAW;
    return g;
  endfunction

  localparam grid_t INIT = make_init();

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_tick = 1'b0;
  logic [1:0]      req = '0;
  logic [1:0][3:0] req_x = '0;
  logic [1:0][2:0] req_y = '0;
  logic [1:0][3:0] req_exp = '0;
  logic [1:0][3:0] req_val = '0;
  logic [1:0]      ack, ok;
  grid_t           grid;
  logic            busy;

  int checks = 0;
  int failures = 0;

  grid_state_controller #(
    .COOK_FRAMES(2),
    .BURN_FRAMES(3),
    .AGE_W      (9),
    .INIT_GRID  (INIT)
  ) dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .frame_tick_in  (frame_tick),
    .req_in         (req),
    .req_x_in       (req_x),
    .req_y_in       (req_y),
    .req_expect_in  (req_exp),
    .req_value_in   (req_val),
    .ack_out        (ack),
    .ok_out         (ok),
    .object_grid_out(grid),
    .scan_busy_out  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [3:0] x, input logic [2:0] y,
                         input logic [3:0] e, input logic [3:0] v);
    req_x[p]   = x;
    req_y[p]   = y;
    req_exp[p] = e;
    req_val[p] = v;
    req[p]     = 1'b1;
  endtask

  // Pulses one frame tick and returns how many sampled cycles scan_busy stayed high.
  task automatic run_scan(output int n);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    logic ack_seen;

    // Reset state
    repeat (2) step();
    check("rst_onion", 32'(grid[2][3]), 32'd1);
    check("rst_pot", 32'(grid[5][7]), 32'(G_POT_RAW));
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Single successful CAS, held request must not regrant
    set_req(0, 4'd3, 3'd2, 4'd1, 4'd2);
    step();
    check("cas_ack", 32'(ack), 32'b01);
    check("cas_ok", 32'(ok), 32'b01);
    check("cas_grid", 32'(grid[2][3]), 32'd2);
    step();
    check("cas_noregrant", 32'(ack), 32'd0);
    req = '0;
    step();

    // Contention on one cell after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    set_req(0, 4'd3, 3'd2, 4'd1, 4'd0);
    set_req(1, 4'd3, 3'd2, 4'd1, 4'd0);
    step();
    check("both_ack1", 32'(ack), 32'b01);
    check("both_ok1", 32'(ok), 32'b01);
    check("both_grid", 32'(grid[2][3]), 32'd0);
    req[0] = 1'b0;
    step();
    check("both_ack2", 32'(ack), 32'b10);
    check("both_ok2", 32'(ok), 32'b00);
    req = '0;
    step();
    // rr_ptr now points at player 2
    set_req(0, 4'd0, 3'd0, 4'd0, 4'd8);
    set_req(1, 4'd0, 3'd0, 4'd0, 4'd7);
    step();
    check("rr_ack", 32'(ack), 32'b10);
    check("rr_grid", 32'(grid[0][0]), 32'd7);
    req[1] = 1'b0;
    step();
    check("rr_ack_p1", 32'(ack), 32'b01);
    check("rr_ok_p1", 32'(ok), 32'b00);
    req = '0;
    step();

    // Out-of-range column
    set_req(0, 4'd13, 3'd0, 4'd0, 4'd9);
    step();
    check("oor_ack", 32'(ack), 32'b01);
    check("oor_ok", 32'(ok), 32'b00);
    check("oor_cell00", 32'(grid[0][0]), 32'd7);
    check("oor_cell10", 32'(grid[1][0]), 32'd0);
    req = '0;
    step();

    // Pot cooking: raw -> cooked after 2 scans, -> fire after 3 more
    for (int s = 1; s <= 5; s++) begin
      run_scan(n);
      check($sformatf("scan_len%0d", s), 32'(n), 32'd104);
      check($sformatf("pot%0d", s), 32'(grid[5][7]),
            (s < 2) ? 32'(G_POT_RAW) : (s < 5) ? 32'(G_POT_COOKED) : 32'(G_POT_FIRE));
    end

    // Queued rescan with a dropped third tick; a request waits through both scans
    set_req(0, 4'd0, 3'd0, 4'd7, 4'd8);
    frame_tick = 1'b1;
    step();
    n = 0;
    ack_seen = 1'b0;
    while (busy && n < 500) begin
      n++;
      ack_seen |= ack[0];
      frame_tick = (n == 10) || (n == 50);
      step();
    end
    frame_tick = 1'b0;
    check("rescan_len", 32'(n), 32'd208);
    check("stall_noack", 32'(ack_seen), 32'd0);
    step();
    check("post_scan_ack", 32'(ack), 32'b01);
    check("post_scan_ok", 32'(ok), 32'b01);
    check("post_scan_grid", 32'(grid[0][0]), 32'd8);
    check("fire_stays", 32'(grid[5][7]), 32'(G_POT_FIRE));
    req = '0;
    step();

    // Asynchronous reset in the middle of a scan
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (30) step();
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_grid", 32'(grid == INIT), 32'd1);
    check("mid_rst_ack", 32'(ack), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("after_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
